// File: rtl/instruction_decoder_pkg.sv
// Shared constants and types for the instruction decoder: opcode fields, register indices, FSM states.
// No logic of its own; latency and backpressure do not apply.
package instruction_decoder_pkg;

   localparam logic       OP_LOAD = 1'b0;      // ir[7]
   localparam logic [1:0] OP_MOV  = 2'b10;     // ir[7:6]
   localparam logic [2:0] OP_ALU  = 3'b110;    // ir[7:5]
   localparam logic [3:0] OP_JMP  = 4'b1110;   // ir[7:4]
   localparam logic [3:0] OP_JNZ  = 4'b1111;   // ir[7:4]

   localparam logic [2:0] R_X0   = 3'd0;
   localparam logic [2:0] R_X1   = 3'd1;
   localparam logic [2:0] R_Y0   = 3'd2;
   localparam logic [2:0] R_Y1   = 3'd3;
   localparam logic [2:0] R_O    = 3'd4;
   localparam logic [2:0] R_M    = 3'd5;
   localparam logic [2:0] R_I    = 3'd6;
   localparam logic [2:0] R_NONE = 3'd7;

   localparam logic [3:0] SRC_IMM  = 4'd8;
   localparam logic [7:0] NOP_WORD = 8'hBF;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   // Destination index 7 (R_NONE) selects no register.
   function automatic logic [6:0] reg_onehot(input logic [2:0] idx);
      logic [6:0] v;
      v = '0;
      for (int i = 0; i < 7; i++) begin
         v[i] = (idx == 3'(i));
      end
      return v;
   endfunction

endpackage

// File: rtl/instruction_decoder_field_decode.sv
// Pure combinational split of the effective instruction word into sequencer/datapath controls.
// Zero latency; no flow control.
module instr_field_decode
   import instruction_decoder_pkg::*;
(
   input  logic [7:0] i_ir,
   output logic       o_jmp,
   output logic       o_jmp_nz,
   output logic [3:0] o_jmp_addr,
   output logic [6:0] o_reg_en,
   output logic [3:0] o_src_sel,
   output logic [3:0] o_imm,
   output logic       o_alu_en,
   output logic       o_x_sel,
   output logic       o_y_sel,
   output logic [2:0] o_alu_func
);

   always_comb begin
      o_jmp      = 1'b0;
      o_jmp_nz   = 1'b0;
      o_jmp_addr = 4'h0;
      o_reg_en   = 7'h00;
      o_src_sel  = 4'h0;
      o_imm      = 4'h0;
      o_alu_en   = 1'b0;
      o_x_sel    = 1'b0;
      o_y_sel    = 1'b0;
      o_alu_func = 3'h0;
      if (i_ir[7] == OP_LOAD) begin
         o_reg_en  = reg_onehot(i_ir[6:4]);
         o_src_sel = SRC_IMM;
         o_imm     = i_ir[3:0];
      end else if (i_ir[7:6] == OP_MOV) begin
         o_reg_en  = reg_onehot(i_ir[5:3]);
         o_src_sel = (i_ir[2:0] == R_NONE) ? 4'h0 : {1'b0, i_ir[2:0]};
      end else if (i_ir[7:5] == OP_ALU) begin
         o_alu_en   = 1'b1;
         o_x_sel    = i_ir[4];
         o_y_sel    = i_ir[3];
         o_alu_func = i_ir[2:0];
      end else if (i_ir[7:4] == OP_JMP) begin
         o_jmp      = 1'b1;
         o_jmp_addr = i_ir[3:0];
      end else begin
         o_jmp_nz   = 1'b1;
         o_jmp_addr = i_ir[3:0];
      end
   end

endmodule

// File: rtl/instruction_decoder.sv
// Instruction decoder: RESET/PRIME/RUN sequencing, zero flag, saturating retired-instruction counter.
// Decode is combinational from pm_data (0 cycles); flag and counter update at the edge; no backpressure.
module instruction_decoder #(
   parameter int         CNT_W    = 16,
   parameter logic [7:0] NOP_WORD = instruction_decoder_pkg::NOP_WORD
) (
   input  logic             clk,
   input  logic             sync_reset,
   input  logic [7:0]       pm_data,
   input  logic             alu_zero,
   output logic             jmp,
   output logic             jmp_nz,
   output logic [3:0]       jmp_addr,
   output logic             dont_jmp,
   output logic [6:0]       reg_en,
   output logic [3:0]       src_sel,
   output logic [3:0]       imm,
   output logic             alu_en,
   output logic             x_sel,
   output logic             y_sel,
   output logic [2:0]       alu_func,
   output logic [CNT_W-1:0] instr_count
);
   import instruction_decoder_pkg::*;

   state_t           r_state;
   state_t           w_next;
   logic             w_run;
   logic [7:0]       w_ir;
   logic             w_alu_en;
   logic             r_z;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (sync_reset) r_state <= ST_RESET;
      else            r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_RESET: w_next = ST_PRIME;
         ST_PRIME: w_next = ST_RUN;
         ST_RUN:   w_next = ST_RUN;
         default:  w_next = ST_RESET;
      endcase
   end

   // The ROM output lags pm_addr by a cycle, so RESET and PRIME both see stale data.
   assign w_run = (r_state == ST_RUN);
   assign w_ir  = w_run ? pm_data : NOP_WORD;

   instr_field_decode u_decode (
      .i_ir       (w_ir),
      .o_jmp      (jmp),
      .o_jmp_nz   (jmp_nz),
      .o_jmp_addr (jmp_addr),
      .o_reg_en   (reg_en),
      .o_src_sel  (src_sel),
      .o_imm      (imm),
      .o_alu_en   (w_alu_en),
      .o_x_sel    (x_sel),
      .o_y_sel    (y_sel),
      .o_alu_func (alu_func)
   );

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         r_z   <= 1'b0;
         r_cnt <= '0;
      end else begin
         if (w_run && w_alu_en)      r_z   <= alu_zero;
         if (w_run && (r_cnt != '1)) r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign alu_en      = w_alu_en;
   assign dont_jmp    = r_z;
   assign instr_count = r_cnt;

endmodule

// File: tb/tb_instruction_decoder.sv
// Randomized plus directed bench for instruction_decoder against an arithmetic reference model.
// Two instances share stimulus: default counter width and a 4-bit counter for saturation.
module tb_instruction_decoder;

   logic        clk = 1'b0;
   logic        sync_reset;
   logic [7:0]  pm_data;
   logic        alu_zero;

   logic        jmp, jmp_nz, dont_jmp, alu_en, x_sel, y_sel;
   logic [3:0]  jmp_addr, src_sel, imm;
   logic [6:0]  reg_en;
   logic [2:0]  alu_func;
   logic [15:0] instr_count;

   logic        s_jmp, s_jmp_nz, s_dont_jmp, s_alu_en, s_x_sel, s_y_sel;
   logic [3:0]  s_jmp_addr, s_src_sel, s_imm;
   logic [6:0]  s_reg_en;
   logic [2:0]  s_alu_func;
   logic [3:0]  s_instr_count;

   int checks = 0;
   int errors = 0;

   // Reference model state: cycles since reset release, flag, unsaturated count.
   bit m_known = 0;
   int m_phase = 0;
   bit m_z     = 0;
   int m_cnt   = 0;

   always #5 clk = ~clk;

   instruction_decoder #(.CNT_W(16)) dut (
      .clk(clk), .sync_reset(sync_reset), .pm_data(pm_data), .alu_zero(alu_zero),
      .jmp(jmp), .jmp_nz(jmp_nz), .jmp_addr(jmp_addr), .dont_jmp(dont_jmp),
      .reg_en(reg_en), .src_sel(src_sel), .imm(imm), .alu_en(alu_en),
      .x_sel(x_sel), .y_sel(y_sel), .alu_func(alu_func), .instr_count(instr_count)
   );

   instruction_decoder #(.CNT_W(4)) dut_sat (
      .clk(clk), .sync_reset(sync_reset), .pm_data(pm_data), .alu_zero(alu_zero),
      .jmp(s_jmp), .jmp_nz(s_jmp_nz), .jmp_addr(s_jmp_addr), .dont_jmp(s_dont_jmp),
      .reg_en(s_reg_en), .src_sel(s_src_sel), .imm(s_imm), .alu_en(s_alu_en),
      .x_sel(s_x_sel), .y_sel(s_y_sel), .alu_func(s_alu_func), .instr_count(s_instr_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input logic [7:0] pm);
      int v, d, s;
      int e_jmp, e_jnz, e_addr, e_reg, e_src, e_imm, e_alu, e_x, e_y, e_f;
      e_jmp = 0; e_jnz = 0; e_addr = 0; e_reg = 0; e_src = 0;
      e_imm = 0; e_alu = 0; e_x = 0; e_y = 0; e_f = 0;
      v = (m_phase == 2) ? int'(pm) : 191;
      if (v < 128) begin
         d = v / 16;
         if (d != 7) e_reg = 1 << d;
         e_src = 8;
         e_imm = v % 16;
      end else if (v < 192) begin
         d = (v - 128) / 8;
         s = v % 8;
         if (d != 7) e_reg = 1 << d;
         e_src = (s == 7) ? 0 : s;
      end else if (v < 224) begin
         e_alu = 1;
         e_x = (v / 16) % 2;
         e_y = (v / 8) % 2;
         e_f = v % 8;
      end else if (v < 240) begin
         e_jmp = 1;
         e_addr = v % 16;
      end else begin
         e_jnz = 1;
         e_addr = v % 16;
      end
      chk("jmp",      32'(jmp),      32'(e_jmp));
      chk("jmp_nz",   32'(jmp_nz),   32'(e_jnz));
      chk("jmp_addr", 32'(jmp_addr), 32'(e_addr));
      chk("reg_en",   32'(reg_en),   32'(e_reg));
      chk("src_sel",  32'(src_sel),  32'(e_src));
      chk("imm",      32'(imm),      32'(e_imm));
      chk("alu_en",   32'(alu_en),   32'(e_alu));
      chk("x_sel",    32'(x_sel),    32'(e_x));
      chk("y_sel",    32'(y_sel),    32'(e_y));
      chk("alu_func", 32'(alu_func), 32'(e_f));
      chk("dont_jmp", 32'(dont_jmp), 32'(m_z));
      chk("count16",  32'(instr_count),   32'((m_cnt > 65535) ? 65535 : m_cnt));
      chk("count4",   32'(s_instr_count), 32'((m_cnt > 15) ? 15 : m_cnt));
      chk("jmp_excl", 32'(jmp & jmp_nz),  32'(0));
   endtask

   task automatic cycle(input logic [7:0] pm, input logic az, input logic rst);
      sync_reset = rst;
      pm_data    = pm;
      alu_zero   = az;
      #2;
      if (m_known) check_outputs(pm);
      @(posedge clk);
      if (rst) begin
         m_known = 1;
         m_phase = 0;
         m_z     = 0;
         m_cnt   = 0;
      end else begin
         if (m_phase == 2) begin
            m_cnt++;
            if (pm >= 8'd192 && pm < 8'd224) m_z = az;
         end
         if (m_phase < 2) m_phase++;
      end
      #1;
   endtask

   initial begin
      sync_reset = 1'b1;
      pm_data    = 8'hE5;
      alu_zero   = 1'b0;

      repeat (3) cycle(8'hE5, 1'b0, 1'b1);
      repeat (3) cycle(8'hE5, 1'b0, 1'b0);   // two NOP cycles, then the jump

      cycle(8'h3A, 1'b0, 1'b0);
      cycle(8'h8A, 1'b0, 1'b0);
      cycle(8'hD3, 1'b1, 1'b0);
      cycle(8'hF4, 1'b0, 1'b0);
      cycle(8'hD3, 1'b0, 1'b0);
      cycle(8'hF4, 1'b1, 1'b0);

      cycle(8'hD3, 1'b1, 1'b0);
      cycle(8'h3A, 1'b0, 1'b0);
      cycle(8'h8A, 1'b0, 1'b0);
      cycle(8'hE5, 1'b0, 1'b0);
      cycle(8'hF4, 1'b0, 1'b0);
      cycle(8'hBF, 1'b0, 1'b0);
      cycle(8'h7F, 1'b1, 1'b0);

      repeat (10) cycle(8'($urandom_range(255)), 1'($urandom), 1'b0);
      cycle(8'hDF, 1'b1, 1'b0);               // leave z=1 before the mid-run reset
      cycle(8'hF1, 1'b0, 1'b1);
      repeat (4) cycle(8'hE7, 1'b1, 1'b0);

      repeat (25) cycle(8'($urandom_range(255)), 1'($urandom), 1'b0);

      for (int i = 0; i < 600; i++) begin
         cycle(8'($urandom_range(255)), 1'($urandom), ($urandom_range(49) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
